train_seq: RTL and testbench
============================

# train_seq

Training-loop sequencer for the backpropagation network. It owns the address and read-enable lines of the constant memories (k1, k2, …) that share one 16-bit tristate data bus. For every epoch it steps through the training samples. For each sample it reads each memory in turn, one per cycle, so exactly one memory drives the bus at a time. It then presents the sample to the learning datapath through a valid/ready handshake.

## Interface
- AWIDTH, 4: memory address width; sample index range 0..2**AWIDTH-1
- NSAMPLE, 4: training samples per epoch (1..2**AWIDTH)
- NMEM, 2: memories sharing the bus (1..8)
- EPOCH_W, 16: width of epoch count
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  pulse; begin a run when idle
- abort  in  1  terminate the run
- epochs  in  EPOCH_W  number of epochs; sampled on accepted start
- dp_ready  in  1  datapath has consumed the current sample
- addr  out  AWIDTH  sample index driven to every memory
- rd_en  out  NMEM  one-hot read enable (memory din); zero or one bit set
- cap_vld  out  1  the bus carries valid memory data this cycle
- cap_sel  out  3  index of the memory driving the bus when cap_vld=1
- sample_valid  out  1  all NMEM words of the current sample delivered
- epoch_cnt  out  EPOCH_W  completed epochs
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at normal completion

## Operation
- States: IDLE, FETCH, DRAIN, WAIT, DONE.
- IDLE: if start=1, then:
  - latch epochs, clear epoch_cnt, set sample index to 0;
  - next state is FETCH, or DONE if epochs=0.
- FETCH: NMEM cycles. In FETCH cycle j, rd_en = 1<<j, and addr holds the sample index. After j=NMEM-1, go to DRAIN.
- Memories register data on the edge that samples rd_en. In the cycle after rd_en[j]: cap_vld=1, cap_sel=j.
- DRAIN: one cycle. rd_en=0. The last memory's data is on the bus (cap_vld=1, cap_sel=NMEM-1). Next state is WAIT.
- WAIT: sample_valid=1 and rd_en=0. The handshake completes in any WAIT cycle with dp_ready=1. On completion:
  - if the sample is not the last of the epoch, advance the sample index and go to FETCH;
  - otherwise, increment epoch_cnt and reset the sample index;
  - then go to FETCH if epoch_cnt < epochs, or to DONE if not.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 in every state except IDLE. A start while busy is ignored.
- abort=1 in any non-IDLE state:
  - next state is IDLE;
  - rd_en, cap_vld, sample_valid and done all go to 0 on the next edge;
  - epoch_cnt holds its value; done is not pulsed.
- abort and start in the same IDLE cycle: abort wins, and the FSM stays IDLE.
- rd_en is never multi-hot, which guarantees a single bus driver. In IDLE, DRAIN, WAIT and DONE, rd_en=0, so every memory releases the bus (z) one cycle later.
- epoch_cnt counts without wrap. The range is limited by epochs ≤ 2**EPOCH_W-1.

## Timing
- Reset values: addr=0, rd_en=0, cap_vld=0, cap_sel=0, sample_valid=0, epoch_cnt=0, busy=0, done=0; state IDLE.
- start accepted at edge E0: FETCH begins in the following cycle (cycle 1), with rd_en[0]=1 and addr=0.
- Per sample: NMEM FETCH cycles + 1 DRAIN cycle + at least 1 WAIT cycle, i.e. a minimum of NMEM+2 cycles.
- Between samples there are no idle cycles: the cycle after the handshake is FETCH.
- Data latency: rd_en[j] in cycle t → valid data on the bus, with cap_vld=1, in cycle t+1.
- done is asserted in the cycle after the final handshake; busy falls one cycle after done.
- All outputs are registered. dp_ready and abort act on the edge that samples them.

## Configuration
- TRAIN_SEQ_REVERSE_EN defined: on odd epochs (epoch_cnt bit 0 = 1), the sample index runs from NSAMPLE-1 down to 0. Even epochs run ascending. Each epoch still ends after NSAMPLE handshakes.
- Not defined: every epoch runs ascending, 0..NSAMPLE-1.

## Test plan
- Reset mid-run: assert rst during FETCH → all outputs are 0 immediately (asynchronously); the FSM is IDLE after release.
- Basic run: NMEM=2, NSAMPLE=4, epochs=1, dp_ready tied to 1.
  - rd_en sequence 01,10,00,00 repeats 4 times, with addr=0,1,2,3.
  - cap_sel=0,1 in the cycles after each rd_en; done occurs in cycle 17; epoch_cnt=1.
- Backpressure: dp_ready held 0 for 5 WAIT cycles on sample 2 → sample_valid stays 1, rd_en stays 0, addr=2 holds; FETCH of sample 3 starts the cycle after dp_ready=1.
- epochs=0 with start → done pulse in cycle 1, no rd_en activity, epoch_cnt=0.
- Abort in WAIT of epoch 2, sample 1, with epochs=3 → IDLE next cycle, epoch_cnt=1, no done. A later start runs cleanly from addr 0.
- TRAIN_SEQ_REVERSE_EN defined, epochs=2 → addr order 0,1,2,3, then 3,2,1,0; the bus is never multi-driven (rd_en one-hot or zero on every cycle).

Source files
------------

// File: rtl/train_seq.sv
// ---------------------------------------------------------------------------
// train_seq -- training-loop sequencer for the backpropagation network.
//
// Steps through NSAMPLE training samples for a programmable number of epochs.
// For each sample it reads the NMEM constant memories one per cycle.
// The memories share a single 16-bit tristate data bus, so exactly one of
// them is enabled at a time. The sample is then offered to the learning
// datapath through a valid/ready handshake.
//
// Optional feature (compile-time macro TRAIN_SEQ_REVERSE_EN):
//   defined     -> odd epochs walk the sample index downwards (NSAMPLE-1..0)
//   not defined -> every epoch walks upwards (0..NSAMPLE-1)
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst           asynchronous active-high reset
//   start         pulse, begins a run when idle
//   abort         terminates a run in progress (returns to idle)
//   epochs        number of epochs, captured when start is accepted
//   dp_ready      datapath has consumed the current sample
//   addr          sample index driven to every memory
//   rd_en         one-hot (or zero) memory read enables
//   cap_vld       bus carries valid memory data this cycle
//   cap_sel       index of the memory driving the bus when cap_vld=1
//   sample_valid  all NMEM words of the current sample have been delivered
//   epoch_cnt     completed epochs
//   busy          run in progress
//   done          one-cycle pulse at normal completion
// ---------------------------------------------------------------------------
module train_seq #(
  parameter int AWIDTH  = 4,
  parameter int NSAMPLE = 4,
  parameter int NMEM    = 2,
  parameter int EPOCH_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [EPOCH_W-1:0] epochs,
  input  logic               dp_ready,
  output logic [AWIDTH-1:0]  addr,
  output logic [NMEM-1:0]    rd_en,
  output logic               cap_vld,
  output logic [2:0]         cap_sel,
  output logic               sample_valid,
  output logic [EPOCH_W-1:0] epoch_cnt,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WAIT, DONE} state_t;

  localparam logic [AWIDTH-1:0] LAST_SAMP = AWIDTH'(NSAMPLE - 1);
  localparam logic [2:0]        LAST_MEM  = 3'(NMEM - 1);
  localparam logic [NMEM-1:0]   FIRST_EN  = NMEM'(1);

`ifdef TRAIN_SEQ_REVERSE_EN
  localparam logic REVERSE = 1'b1;
`else
  localparam logic REVERSE = 1'b0;
`endif

  state_t             state;
  logic [2:0]         mem_idx;     // memory being read in the current FETCH cycle
  logic [AWIDTH-1:0]  samp_cnt;    // handshakes completed in this epoch
  logic [EPOCH_W-1:0] epochs_lat;

  logic [EPOCH_W-1:0] epoch_nxt;
  logic               more_epochs;
  logic               desc_cur;
  logic               desc_nxt;
  logic [AWIDTH-1:0]  samp_nxt;
  logic [AWIDTH-1:0]  addr_adv;
  logic [AWIDTH-1:0]  addr_first;

  // Position within the epoch is counted upwards; the address is derived
  // from it so that descending epochs need no separate termination test.
  always_comb begin
    epoch_nxt   = epoch_cnt + EPOCH_W'(1);
    more_epochs = (epoch_nxt < epochs_lat);
    desc_cur    = REVERSE & epoch_cnt[0];
    desc_nxt    = REVERSE & epoch_nxt[0];
    samp_nxt    = samp_cnt + AWIDTH'(1);
    addr_adv    = desc_cur ? (LAST_SAMP - samp_nxt) : samp_nxt;
    addr_first  = desc_nxt ? LAST_SAMP : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mem_idx      <= '0;
      samp_cnt     <= '0;
      epochs_lat   <= '0;
      addr         <= '0;
      rd_en        <= '0;
      cap_vld      <= 1'b0;
      cap_sel      <= '0;
      sample_valid <= 1'b0;
      epoch_cnt    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done    <= 1'b0;
      cap_vld <= 1'b0;

      case (state)
        IDLE: begin
          if (start && !abort) begin
            epochs_lat <= epochs;
            epoch_cnt  <= '0;
            samp_cnt   <= '0;
            addr       <= '0;
            mem_idx    <= '0;
            busy       <= 1'b1;
            if (epochs == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
              rd_en <= FIRST_EN;
            end
          end
        end

        FETCH: begin
          // Memory mem_idx samples rd_en on this edge and drives the bus
          // during the next cycle.
          cap_vld <= 1'b1;
          cap_sel <= mem_idx;
          if (mem_idx == LAST_MEM) begin
            rd_en <= '0;
            state <= DRAIN;
          end else begin
            rd_en   <= FIRST_EN << (mem_idx + 3'd1);
            mem_idx <= mem_idx + 3'd1;
          end
        end

        DRAIN: begin
          sample_valid <= 1'b1;
          state        <= WAIT;
        end

        WAIT: begin
          if (dp_ready) begin
            sample_valid <= 1'b0;
            mem_idx      <= '0;
            if (samp_cnt != LAST_SAMP) begin
              samp_cnt <= samp_nxt;
              addr     <= addr_adv;
              rd_en    <= FIRST_EN;
              state    <= FETCH;
            end else begin
              epoch_cnt <= epoch_nxt;
              samp_cnt  <= '0;
              addr      <= addr_first;
              if (more_epochs) begin
                rd_en <= FIRST_EN;
                state <= FETCH;
              end else begin
                done  <= 1'b1;
                state <= DONE;
              end
            end
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase

      // Abort overrides whatever the state logic chose; epoch_cnt is kept.
      if (abort && (state != IDLE)) begin
        state        <= IDLE;
        rd_en        <= '0;
        cap_vld      <= 1'b0;
        sample_valid <= 1'b0;
        done         <= 1'b0;
        busy         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_train_seq.sv
// ---------------------------------------------------------------------------
// tb_train_seq -- scoreboard bench for train_seq.
// A reference model expands each run into the expected read, capture,
// handshake and completion events; a negedge monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_train_seq;

  localparam int AWIDTH  = 4;
  localparam int NSAMPLE = 4;
  localparam int NMEM    = 2;
  localparam int EPOCH_W = 16;

`ifdef TRAIN_SEQ_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [EPOCH_W-1:0] epochs = '0;
  logic               dp_ready = 1'b0;
  logic [AWIDTH-1:0]  addr;
  logic [NMEM-1:0]    rd_en;
  logic               cap_vld;
  logic [2:0]         cap_sel;
  logic               sample_valid;
  logic [EPOCH_W-1:0] epoch_cnt;
  logic               busy;
  logic               done;

  train_seq #(.AWIDTH(AWIDTH), .NSAMPLE(NSAMPLE), .NMEM(NMEM), .EPOCH_W(EPOCH_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .epochs(epochs),
    .dp_ready(dp_ready), .addr(addr), .rd_en(rd_en), .cap_vld(cap_vld),
    .cap_sel(cap_sel), .sample_valid(sample_valid), .epoch_cnt(epoch_cnt),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected events; read/capture entries are encoded as addr*16 + mem.
  int rd_q[$];
  int cap_q[$];
  int hs_q[$];
  int done_q[$];

  logic            mon_en = 1'b0;
  logic [NMEM-1:0] prev_rd = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Sample s of a run (counted from 0 across epochs) maps to this address.
  function automatic int addr_of(input int s);
    int e, p;
    e = s / NSAMPLE;
    p = s % NSAMPLE;
    return (REV && (e % 2 == 1)) ? (NSAMPLE - 1 - p) : p;
  endfunction

  // abort_at < 0: normal completion; otherwise the run is aborted while
  // sample abort_at waits for its handshake.
  task automatic push_run(input int ep, input int abort_at);
    int total, a;
    total = ep * NSAMPLE;
    for (int s = 0; s < total; s++) begin
      if (abort_at >= 0 && s > abort_at) break;
      a = addr_of(s);
      for (int j = 0; j < NMEM; j++) begin
        rd_q.push_back(a * 16 + j);
        cap_q.push_back(a * 16 + j);
      end
      if (s != abort_at) hs_q.push_back(a);
    end
    if (abort_at < 0) done_q.push_back(ep);
  endtask

  always @(negedge clk) begin
    int e;
    if (!mon_en) begin
      prev_rd <= '0;
    end else begin
      chk("rd_onehot0", longint'($onehot0(rd_en)), 1);
      if (rd_en != '0) begin
        if (rd_q.size() == 0) chk("rd_unexpected", rd_en, 0);
        else begin
          e = rd_q.pop_front();
          chk("rd_en", rd_en, 1 << (e % 16));
          chk("rd_addr", addr, e / 16);
        end
      end
      if (prev_rd != '0) chk("cap_latency", cap_vld, 1);
      if (cap_vld) begin
        if (cap_q.size() == 0) chk("cap_unexpected", cap_vld, 0);
        else begin
          e = cap_q.pop_front();
          chk("cap_sel", cap_sel, e % 16);
          chk("cap_addr", addr, e / 16);
        end
      end
      if (sample_valid && dp_ready) begin
        if (hs_q.size() == 0) chk("hs_unexpected", sample_valid, 0);
        else begin
          e = hs_q.pop_front();
          chk("hs_addr", addr, e);
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("done_unexpected", done, 0);
        else begin
          e = done_q.pop_front();
          chk("done_epoch_cnt", epoch_cnt, e);
        end
      end
      prev_rd <= rd_en;
    end
  end

  // rdy_mode: 0 random dp_ready, 1 always ready.
  // stall_at: sample held off for 5 WAIT cycles (-1 none).
  // exp_done_cyc: expected done cycle after the start edge (0 = unchecked).
  task automatic run(input int ep, input int abort_at, input int stall_at,
                     input int rdy_mode, input int exp_done_cyc);
    int cyc, sidx, stall;
    bit finished, chk_next;
    push_run(ep, abort_at);
    @(posedge clk); #1;
    start = 1'b1;
    epochs = EPOCH_W'(ep);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; sidx = 0; stall = 0; finished = 1'b0; chk_next = 1'b0;
    while (!finished && cyc < 3000) begin
      if (done) begin
        if (exp_done_cyc > 0) chk("done_cycle", cyc, exp_done_cyc);
        finished = 1'b1;
        @(posedge clk); #1;
        chk("done_pulse_width", done, 0);
        chk("busy_after_done", busy, 0);
      end else if (sample_valid && sidx == abort_at) begin
        abort = 1'b1;
        dp_ready = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_sample_valid", sample_valid, 0);
        chk("abort_rd_en", rd_en, 0);
        chk("abort_done", done, 0);
        chk("abort_epoch_cnt", epoch_cnt, abort_at / NSAMPLE);
        finished = 1'b1;
      end else begin
        if (sample_valid && sidx == stall_at && stall < 5) begin
          dp_ready = 1'b0;
          chk("stall_sample_valid", sample_valid, 1);
          chk("stall_rd_en", rd_en, 0);
          chk("stall_addr", addr, addr_of(stall_at));
          stall++;
        end else begin
          dp_ready = (rdy_mode == 1) ? 1'b1 : (($urandom % 3) != 0);
          if (sample_valid && dp_ready) begin
            if (sidx == stall_at) chk_next = 1'b1;
            sidx++;
          end
        end
        @(posedge clk); #1;
        cyc++;
        if (chk_next) begin
          chk("post_stall_rd_en", rd_en, 1);
          chk("post_stall_addr", addr, addr_of(stall_at + 1));
          chk_next = 1'b0;
        end
      end
    end
    if (!finished) chk("run_timeout", 0, 1);
    dp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rd_q_empty", rd_q.size(), 0);
    chk("cap_q_empty", cap_q.size(), 0);
    chk("hs_q_empty", hs_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_cap_vld"}, cap_vld, 0);
    chk({tag, "_cap_sel"}, cap_sel, 0);
    chk({tag, "_sample_valid"}, sample_valid, 0);
    chk({tag, "_epoch_cnt"}, epoch_cnt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    // Basic run: done in cycle (NMEM+2)*NSAMPLE + 1 with dp_ready tied high.
    run(1, -1, -1, 1, (NMEM + 2) * NSAMPLE + 1);
    chk("basic_epoch_cnt", epoch_cnt, 1);

    // Backpressure on sample 2.
    run(1, -1, 2, 1, 0);

    // Zero epochs: immediate done, no reads.
    run(0, -1, -1, 1, 1);
    chk("zero_epoch_cnt", epoch_cnt, 0);

    // Abort in WAIT of the second epoch, sample 1, then a clean rerun.
    run(3, NSAMPLE + 1, -1, 0, 0);
    chk("after_abort_epoch_cnt", epoch_cnt, 1);
    run(1, -1, -1, 0, 0);

    // Start and abort together in IDLE: nothing starts.
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; epochs = 16'd2;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_rd_en", rd_en, 0);
    chk("start_abort_done", done, 0);

    // Two epochs (exercises the descending order when enabled).
    run(2, -1, -1, 0, 0);

    // Randomized runs.
    for (int r = 0; r < 4; r++) run(int'($urandom_range(1, 3)), -1, -1, 0, 0);

    // Asynchronous reset during FETCH.
    @(posedge clk); #1;
    start = 1'b1; epochs = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    mon_en = 1'b0;
    chk("pre_reset_rd_en", rd_en, 1);
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    rd_q.delete(); cap_q.delete(); hs_q.delete(); done_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_busy", busy, 0);
    mon_en = 1'b1;
    run(1, -1, -1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
